reg_bank_paired: RTL and testbench
==================================

// Module: reg_bank_paired
// PURPOSE
//   Parametrised general-purpose register bank for the CPU datapath. Replaces the
//   per-register instances with one block. Adds these features:
//   - two registered read ports and one write port, with write-first bypass;
//   - register pairs (even = high byte, odd = low byte) driving a 2*DATA_W pointer
//     onto the address bus;
//   - pair load, post-increment and post-decrement, with a wrap flag.
// PARAMETERS
//   DATA_W     8   width of each register / data bus
//   NUM_REGS   8   register count; must be even and >= 2
//   RESET_VAL  0   value loaded into every register on reset (DATA_W bits)
//   localparam SEL_W  = $clog2(NUM_REGS)   register select width
//   localparam PAIR_W = max(SEL_W-1,1)     pair select width
// PORTS
//   clk          in   1          rising-edge clock
//   rst          in   1          asynchronous, active-high reset
//   wr_en        in   1          write wr_data into register wr_sel
//   wr_sel       in   SEL_W      write register index
//   wr_data      in   DATA_W     write data (from data bus)
//   rd_a_sel     in   SEL_W      read port A register index
//   rd_a_data    out  DATA_W     read port A data, registered
//   rd_b_sel     in   SEL_W      read port B register index
//   rd_b_data    out  DATA_W     read port B data, registered
//   pair_sel     in   PAIR_W     selected pair p = regs {2p, 2p+1}
//   pair_ld      in   1          load pair from pair_ld_data
//   pair_ld_data in   2*DATA_W   pair load value ([hi]=reg 2p, [lo]=reg 2p+1)
//   pair_inc     in   1          post-increment selected pair by 1
//   pair_dec     in   1          post-decrement selected pair by 1
//   pair_addr    out  2*DATA_W   combinational {reg 2p, reg 2p+1} for address bus
//   pair_wrap    out  1          one-cycle pulse: last inc/dec wrapped
// BEHAVIOUR
// - Reset (async, while rst=1):
//     all registers = RESET_VAL; rd_a_data = rd_b_data = 0; pair_wrap = 0.
//     pair_addr = {RESET_VAL, RESET_VAL} via combinational path.
//     Reset mid-operation discards any pending inc/dec/write; no partial update.
// - Write: on posedge with wr_en=1, reg[wr_sel] <= wr_data.
//     wr_sel >= NUM_REGS is ignored.
// - Read: on each posedge, rd_x_data <= reg[rd_x_sel] (1-cycle latency).
//     Write-first bypass: if wr_en && wr_sel==rd_x_sel in the same cycle,
//     rd_x_data <= wr_data, unless the pair op below overrides that register.
//     In that case rd_x_data gets the pair-op result byte.
//     Out-of-range rd_x_sel returns 0.
// - pair_addr is combinational from current register contents; no latency.
//     Updated values from ld/inc/dec are visible the cycle after the edge.
// - Pair arithmetic on the 2*DATA_W value P = {reg[2p], reg[2p+1}}, modulo 2^(2*DATA_W):
//     pair_ld=1             : P <= pair_ld_data  (highest priority; inc/dec ignored)
//     pair_inc=1, pair_dec=0 : P <= P+1; carry from low into high byte
//     pair_dec=1, pair_inc=0 : P <= P-1; borrow from high byte
//     pair_inc=1, pair_dec=1 : no change, no wrap
// - pair_wrap: registered; 1 for exactly the cycle after one of:
//     inc from all-ones to 0; dec from 0 to all-ones. Otherwise 0.
//     pair_ld never sets it.
// - Collision: a pair op (ld/inc/dec) targets the same register as wr_en.
//     The pair op wins for both bytes of the pair; the write is dropped.
//     wr_en to a register outside the selected pair proceeds in the same cycle.
// - pair_sel is sampled at the edge; an out-of-range pair performs no update.
// - No internal FSM beyond the register state; every operation completes in
//   one cycle. There is no busy/stall output.
// TESTING
// 1 Reset: assert rst asynchronously mid-cycle with RESET_VAL=8'h00.
//     -> all regs 0, rd_a_data=rd_b_data=0, pair_addr=16'h0000, pair_wrap=0
//        immediately, before the next clock edge.
// 2 Write/read: wr r3=8'hA5; next cycle rd_a_sel=3 -> rd_a_data=8'hA5 one edge later.
//     Bypass: same cycle wr r5=8'h3C with rd_b_sel=5 -> rd_b_data=8'h3C after one edge.
// 3 Pair carry: ld pair1 = 16'h12FF, then pair_inc -> pair_addr=16'h1300,
//     r2=8'h13, r3=8'h00, pair_wrap=0.
// 4 Wrap:
//     ld pair0 = 16'hFFFF, inc -> pair_addr=16'h0000 and pair_wrap=1 for one cycle.
//     Then dec -> 16'hFFFF and pair_wrap=1.
//     Then inc+dec together -> unchanged and pair_wrap=0.
// 5 Collision: pair2=16'h0010; same cycle pair_inc on pair 2 and wr r4=8'h77.
//     -> pair_addr=16'h0011 (write dropped).
//     Repeat with wr r0=8'h77 instead -> r0=8'h77 and pair incremented.
// 6 Param sweep: DATA_W=16, NUM_REGS=4.
//     ld pair1 = 32'h0000_FFFF, inc -> 32'h0001_0000.
//     Out-of-range selects are ignored and return 0.

Source files
------------

// File: rtl/reg_bank_paired_if.sv
// reg_bank_paired_if: register bank access bus (write, two reads, pair pointer ops)
interface reg_bank_paired_if #(
    parameter int DATA_W = 8,
    parameter int NUM_REGS = 8
);
    localparam int SEL_W = $clog2(NUM_REGS);
    localparam int PAIR_W = SEL_W > 1 ? SEL_W - 1 : 1;
    logic wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [SEL_W-1:0] rd_a_sel;
    logic [DATA_W-1:0] rd_a_data;
    logic [SEL_W-1:0] rd_b_sel;
    logic [DATA_W-1:0] rd_b_data;
    logic [PAIR_W-1:0] pair_sel;
    logic pair_ld;
    logic [2*DATA_W-1:0] pair_ld_data;
    logic pair_inc;
    logic pair_dec;
    logic [2*DATA_W-1:0] pair_addr;
    logic pair_wrap;
    modport master (
        output wr_en, wr_sel, wr_data, rd_a_sel, rd_b_sel, pair_sel, pair_ld, pair_ld_data, pair_inc, pair_dec,
        input rd_a_data, rd_b_data, pair_addr, pair_wrap
    );
    modport slave (
        input wr_en, wr_sel, wr_data, rd_a_sel, rd_b_sel, pair_sel, pair_ld, pair_ld_data, pair_inc, pair_dec,
        output rd_a_data, rd_b_data, pair_addr, pair_wrap
    );
endinterface

// File: rtl/reg_bank_paired.sv
// reg_bank_paired: register bank with two registered read ports, one write port and pair pointer arithmetic
module reg_bank_paired #(
    parameter int DATA_W = 8,
    parameter int NUM_REGS = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input logic clk,
    input logic rst,
    reg_bank_paired_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_REGS);
    localparam int PAIR_W = SEL_W > 1 ? SEL_W - 1 : 1;
    localparam int PW = 2 * DATA_W;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] nxt [NUM_REGS];
    logic [PW-1:0] cur, res;
    logic hit, upd, wrap_n, wrap;
    logic [DATA_W-1:0] rd_a, rd_b, rd_a_n, rd_b_n;
    always_comb begin
        cur = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS / 2; i++)
            if (bus.pair_sel == PAIR_W'(i)) begin
                cur = {regs[2*i], regs[2*i+1]};
                hit = 1'b1;
            end
    end
    assign upd = hit && (bus.pair_ld || (bus.pair_inc ^ bus.pair_dec));
    assign res = bus.pair_ld ? bus.pair_ld_data : bus.pair_inc ? cur + PW'(1) : cur - PW'(1);
    assign wrap_n = hit && !bus.pair_ld &&
                    ((bus.pair_inc && !bus.pair_dec && cur == '1) || (bus.pair_dec && !bus.pair_inc && cur == '0));
    // a pair op owns both bytes of its pair, so a colliding write is dropped there
    always_comb
        for (int i = 0; i < NUM_REGS; i++)
            nxt[i] = upd && bus.pair_sel == PAIR_W'(i / 2) ? (i % 2 == 0 ? res[PW-1:DATA_W] : res[DATA_W-1:0])
                   : bus.wr_en && bus.wr_sel == SEL_W'(i) ? bus.wr_data : regs[i];
    // reads see next-state values, giving write-first bypass and pair-op override
    always_comb begin
        rd_a_n = '0;
        rd_b_n = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_a_sel == SEL_W'(i)) rd_a_n = nxt[i];
            if (bus.rd_b_sel == SEL_W'(i)) rd_b_n = nxt[i];
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
            rd_a <= '0;
            rd_b <= '0;
            wrap <= 1'b0;
        end else begin
            regs <= nxt;
            rd_a <= rd_a_n;
            rd_b <= rd_b_n;
            wrap <= wrap_n;
        end
    assign bus.rd_a_data = rd_a;
    assign bus.rd_b_data = rd_b;
    assign bus.pair_addr = cur;
    assign bus.pair_wrap = wrap;
endmodule

// File: tb/tb_reg_bank_paired.sv
// tb_reg_bank_paired: directed checks of reset, read/write bypass, pair arithmetic, collisions and widths
module tb_reg_bank_paired;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  reg_bank_paired_if #(.DATA_W(8), .NUM_REGS(8)) b0 ();
  reg_bank_paired_if #(.DATA_W(16), .NUM_REGS(4)) b1 ();
  reg_bank_paired_if #(.DATA_W(8), .NUM_REGS(6)) b2 ();
  reg_bank_paired #(.DATA_W(8), .NUM_REGS(8), .RESET_VAL(8'h00)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  reg_bank_paired #(.DATA_W(16), .NUM_REGS(4), .RESET_VAL(16'h0000)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  reg_bank_paired #(.DATA_W(8), .NUM_REGS(6), .RESET_VAL(8'h5A)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    {b0.wr_en, b0.wr_sel, b0.wr_data, b0.rd_a_sel, b0.rd_b_sel, b0.pair_sel, b0.pair_ld, b0.pair_ld_data, b0.pair_inc, b0.pair_dec} = '0;
    {b1.wr_en, b1.wr_sel, b1.wr_data, b1.rd_a_sel, b1.rd_b_sel, b1.pair_sel, b1.pair_ld, b1.pair_ld_data, b1.pair_inc, b1.pair_dec} = '0;
    {b2.wr_en, b2.wr_sel, b2.wr_data, b2.rd_a_sel, b2.rd_b_sel, b2.pair_sel, b2.pair_ld, b2.pair_ld_data, b2.pair_inc, b2.pair_dec} = '0;
    tick;
    tick;
    chk("reset rd_a", b0.rd_a_data, 8'h00);
    chk("reset rd_b", b0.rd_b_data, 8'h00);
    chk("reset pair_addr", b0.pair_addr, 16'h0000);
    chk("reset wrap", b0.pair_wrap, 1'b0);
    chk("reset nonzero pair_addr", b2.pair_addr, 16'h5A5A);
    chk("reset nonzero rd_a", b2.rd_a_data, 8'h00);
    rst = 1'b0;
    tick;
    b0.wr_en = 1'b1; b0.wr_sel = 3'd3; b0.wr_data = 8'hA5;
    tick;
    b0.wr_sel = 3'd5; b0.wr_data = 8'h3C; b0.rd_a_sel = 3'd3; b0.rd_b_sel = 3'd5;
    tick;
    b0.wr_en = 1'b0;
    chk("read r3", b0.rd_a_data, 8'hA5);
    chk("bypass r5", b0.rd_b_data, 8'h3C);
    b0.pair_sel = 2'd1;
    #1;
    chk("pair1 addr", b0.pair_addr, 16'h00A5);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst rd_a", b0.rd_a_data, 8'h00);
    chk("async rst rd_b", b0.rd_b_data, 8'h00);
    chk("async rst pair_addr", b0.pair_addr, 16'h0000);
    chk("async rst wrap", b0.pair_wrap, 1'b0);
    #3;
    rst = 1'b0;
    tick;
    b0.pair_ld = 1'b1; b0.pair_ld_data = 16'h12FF;
    tick;
    b0.pair_ld = 1'b0;
    chk("ld pair1", b0.pair_addr, 16'h12FF);
    b0.pair_inc = 1'b1;
    tick;
    b0.pair_inc = 1'b0;
    chk("carry pair1", b0.pair_addr, 16'h1300);
    chk("carry no wrap", b0.pair_wrap, 1'b0);
    b0.rd_a_sel = 3'd2; b0.rd_b_sel = 3'd3;
    tick;
    chk("carry r2", b0.rd_a_data, 8'h13);
    chk("carry r3", b0.rd_b_data, 8'h00);
    b0.pair_sel = 2'd0; b0.pair_ld = 1'b1; b0.pair_ld_data = 16'hFFFF;
    tick;
    b0.pair_ld = 1'b0;
    chk("ld pair0", b0.pair_addr, 16'hFFFF);
    chk("ld no wrap", b0.pair_wrap, 1'b0);
    b0.pair_inc = 1'b1;
    tick;
    b0.pair_inc = 1'b0;
    chk("inc wrap addr", b0.pair_addr, 16'h0000);
    chk("inc wrap flag", b0.pair_wrap, 1'b1);
    tick;
    chk("wrap one cycle", b0.pair_wrap, 1'b0);
    b0.pair_dec = 1'b1;
    tick;
    chk("dec wrap addr", b0.pair_addr, 16'hFFFF);
    chk("dec wrap flag", b0.pair_wrap, 1'b1);
    b0.pair_inc = 1'b1;
    tick;
    b0.pair_inc = 1'b0; b0.pair_dec = 1'b0;
    chk("inc+dec addr", b0.pair_addr, 16'hFFFF);
    chk("inc+dec wrap", b0.pair_wrap, 1'b0);
    b0.pair_sel = 2'd2; b0.pair_ld = 1'b1; b0.pair_ld_data = 16'h0010;
    tick;
    b0.pair_ld = 1'b0;
    b0.pair_inc = 1'b1; b0.wr_en = 1'b1; b0.wr_sel = 3'd4; b0.wr_data = 8'h77;
    b0.rd_a_sel = 3'd4; b0.rd_b_sel = 3'd5;
    tick;
    chk("collision pair", b0.pair_addr, 16'h0011);
    chk("collision rd r4", b0.rd_a_data, 8'h00);
    chk("collision rd r5", b0.rd_b_data, 8'h11);
    b0.wr_sel = 3'd0; b0.rd_a_sel = 3'd0;
    tick;
    b0.pair_inc = 1'b0; b0.wr_en = 1'b0;
    chk("disjoint pair", b0.pair_addr, 16'h0012);
    chk("disjoint rd r0", b0.rd_a_data, 8'h77);
    b0.pair_sel = 2'd0;
    #1;
    chk("disjoint pair0", b0.pair_addr, 16'h77FF);
    b1.pair_sel = 1'b1; b1.pair_ld = 1'b1; b1.pair_ld_data = 32'h0000_FFFF;
    tick;
    b1.pair_ld = 1'b0; b1.pair_inc = 1'b1;
    tick;
    b1.pair_inc = 1'b0;
    chk("w16 carry", b1.pair_addr, 32'h0001_0000);
    chk("w16 no wrap", b1.pair_wrap, 1'b0);
    b1.pair_dec = 1'b1;
    tick;
    b1.pair_dec = 1'b0;
    chk("w16 borrow", b1.pair_addr, 32'h0000_FFFF);
    b2.rd_a_sel = 3'd6; b2.rd_b_sel = 3'd7;
    b2.wr_en = 1'b1; b2.wr_sel = 3'd7; b2.wr_data = 8'h11;
    b2.pair_sel = 2'd3; b2.pair_ld = 1'b1; b2.pair_ld_data = 16'h1234;
    tick;
    b2.wr_en = 1'b0; b2.pair_ld = 1'b0;
    chk("oor rd_a", b2.rd_a_data, 8'h00);
    chk("oor rd_b", b2.rd_b_data, 8'h00);
    chk("oor pair_addr", b2.pair_addr, 16'h0000);
    b2.pair_sel = 2'd2;
    #1;
    chk("oor pair2 intact", b2.pair_addr, 16'h5A5A);
    b2.rd_a_sel = 3'd5;
    tick;
    chk("oor r5 intact", b2.rd_a_data, 8'h5A);
    b2.pair_sel = 2'd1; b2.pair_inc = 1'b1;
    tick;
    b2.pair_inc = 1'b0;
    chk("resetval inc", b2.pair_addr, 16'h5A5B);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
